rs_station: RTL and testbench
=============================

# rs_station

Reservation station feeding the combinational ALU execution unit in the out-of-order core. It accepts decoded ALU, branch and jump instructions from dispatch and holds them until both source operands are resolved. Results broadcast on the ALU and LSB common data buses wake the waiting operands. Each cycle it issues at most one ready entry, as registered operands, to the execution unit.

## Interface
Parameters:
- RS_SIZE, 16: number of entries; power of two.
- OPENUM_LEN, 6: opcode-enum width; OPENUM_NOP is 0.
- DATA_LEN, 32: operand width.
- ADDR_LEN, 32: pc width.
- ROB_ID_LEN, 4: reorder-buffer tag width.

Ports:
- clk  in  1  clock. One clock domain; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready. When low, all state is held.
- rollback  in  1  misprediction flush.
- ena_dsp  in  1  dispatch valid.
- openum_dsp  in  OPENUM_LEN  operation.
- V1_dsp, V2_dsp  in  DATA_LEN  operand values.
- Q1_busy_dsp, Q2_busy_dsp  in  1  operand not yet available.
- Q1_dsp, Q2_dsp  in  ROB_ID_LEN  producer tags. Meaningful only when the matching busy bit is 1.
- imm_dsp  in  DATA_LEN  immediate.
- pc_dsp  in  ADDR_LEN  instruction pc.
- rob_id_dsp  in  ROB_ID_LEN  destination tag.
- full  out  1  no free entry.
- valid_alu_cdb, valid_lsb_cdb  in  1  broadcast valid.
- rob_id_alu_cdb, rob_id_lsb_cdb  in  ROB_ID_LEN  broadcast tags.
- result_alu_cdb, result_lsb_cdb  in  DATA_LEN  broadcast values.
- openum_to_ex  out  OPENUM_LEN  issued operation; NOP when idle.
- V1_to_ex, V2_to_ex, imm_to_ex  out  DATA_LEN  issued operands.
- pc_to_ex  out  ADDR_LEN  issued pc.
- rob_id_to_ex  out  ROB_ID_LEN  issued destination tag.

## Operation
- Each entry holds: busy, openum, V1, V2, Q1_busy, Q2_busy, Q1, Q2, imm, pc, rob_id.
- Entry is ready when busy && !Q1_busy && !Q2_busy.
- full is combinational from registered state: 1 iff every entry is busy. Dispatch must not assert ena_dsp while full. If it does, the instruction is dropped.
- Dispatch writes the lowest-index entry that is free at the start of the cycle.
- An entry freed by issue in the same cycle is not reused until the next cycle.
- Dispatch-time bypass: if Q1_busy_dsp && valid_alu_cdb && Q1_dsp == rob_id_alu_cdb, store V1 = result_alu_cdb and clear Q1_busy. The same rule applies for the LSB CDB and for operand 2.
- If both CDBs match the same tag, the ALU CDB wins.
- Wakeup: every busy entry with a pending operand whose tag matches a valid CDB tag captures the value and clears that busy bit on the same edge.
- Issue: the lowest-index entry that is ready at the start of the cycle is selected.
  - Its fields are registered onto the *_to_ex outputs.
  - The entry is freed on the same edge.
- If no entry is ready, openum_to_ex <= NOP and the other outputs hold their values.
- An entry woken or dispatched in cycle t is eligible for issue no earlier than cycle t+1.
- Priority per edge: rst > rollback > !rdy > normal operation.
- rollback: all busy bits cleared, openum_to_ex <= NOP, dispatch and CDB in that cycle ignored.
- rdy low: entries unchanged, openum_to_ex <= NOP, dispatch and CDB ignored.

## Timing
- Reset values, applied on the edge where rst=1:
  - all entry busy = 0, so full = 0.
  - openum_to_ex = NOP (0); V1/V2/imm_to_ex = 0; pc_to_ex = 0; rob_id_to_ex = 0.
- Latency, dispatch with operands ready at edge t: entry valid after t; issue selected in cycle t+1; *_to_ex valid after edge t+1. The execution unit result is available in that same following cycle.
- Latency, CDB wakeup at edge t: issue outputs visible after edge t+1 at the earliest.
- Issue throughput is one per cycle. Dispatch throughput is one per cycle.
- Dispatch and issue in the same cycle with one free entry: count is unchanged and full stays 0.
- A tag broadcast one cycle before dispatch is not caught by this station; dispatch must present that operand as ready.

## Test plan
- Reset, then dispatch ADD with V1=5, V2=7 and both busy bits 0 at cycle 1:
  - openum_to_ex = ADD, V1=5, V2=7 after edge 2.
  - NOP after edge 3.
- Dispatch SUB with Q1_busy=1, Q1=3. Hold 4 cycles; openum_to_ex stays NOP.
  - Then valid_lsb_cdb with tag 3 and value 0x10: after the next edge the entry is ready.
  - Issue shows V1=0x10 one edge later.
- Dispatch with Q2=6 busy in the same cycle as valid_alu_cdb tag 6, value 0xAB:
  - issued next edge with V2=0xAB.
  - Also check the ALU/LSB both-match case: the ALU value is taken.
- Fill all 16 entries with blocked operands: full = 1 after the 16th dispatch.
  - One wakeup then issue: full = 0 the cycle after issue.
  - Issue order is lowest index first.
- With 5 blocked entries, pulse rollback: full = 0, openum_to_ex = NOP, and a later CDB for their tags causes no issue.
- Drop rdy for 3 cycles with a ready entry present: NOP output, entry retained. Issue occurs on the first edge after rdy returns high.

Source files
------------

// File: rtl/rs_station_if.sv
// Dispatch, CDB and issue bundle of the ALU reservation station.
// master = dispatch/CDB/execution side, slave = the station.
interface rs_station_if #(
  parameter int OPENUM_LEN = 6,
  parameter int DATA_LEN   = 32,
  parameter int ADDR_LEN   = 32,
  parameter int ROB_ID_LEN = 4
);
  logic                  ena_dsp;
  logic [OPENUM_LEN-1:0] openum_dsp;
  logic [DATA_LEN-1:0]   V1_dsp;
  logic [DATA_LEN-1:0]   V2_dsp;
  logic                  Q1_busy_dsp;
  logic                  Q2_busy_dsp;
  logic [ROB_ID_LEN-1:0] Q1_dsp;
  logic [ROB_ID_LEN-1:0] Q2_dsp;
  logic [DATA_LEN-1:0]   imm_dsp;
  logic [ADDR_LEN-1:0]   pc_dsp;
  logic [ROB_ID_LEN-1:0] rob_id_dsp;
  logic                  full;

  logic                  valid_alu_cdb;
  logic                  valid_lsb_cdb;
  logic [ROB_ID_LEN-1:0] rob_id_alu_cdb;
  logic [ROB_ID_LEN-1:0] rob_id_lsb_cdb;
  logic [DATA_LEN-1:0]   result_alu_cdb;
  logic [DATA_LEN-1:0]   result_lsb_cdb;

  logic [OPENUM_LEN-1:0] openum_to_ex;
  logic [DATA_LEN-1:0]   V1_to_ex;
  logic [DATA_LEN-1:0]   V2_to_ex;
  logic [DATA_LEN-1:0]   imm_to_ex;
  logic [ADDR_LEN-1:0]   pc_to_ex;
  logic [ROB_ID_LEN-1:0] rob_id_to_ex;

  modport master (
    output ena_dsp, openum_dsp, V1_dsp, V2_dsp, Q1_busy_dsp, Q2_busy_dsp,
           Q1_dsp, Q2_dsp, imm_dsp, pc_dsp, rob_id_dsp,
           valid_alu_cdb, valid_lsb_cdb, rob_id_alu_cdb, rob_id_lsb_cdb,
           result_alu_cdb, result_lsb_cdb,
    input  full, openum_to_ex, V1_to_ex, V2_to_ex, imm_to_ex, pc_to_ex, rob_id_to_ex
  );

  modport slave (
    input  ena_dsp, openum_dsp, V1_dsp, V2_dsp, Q1_busy_dsp, Q2_busy_dsp,
           Q1_dsp, Q2_dsp, imm_dsp, pc_dsp, rob_id_dsp,
           valid_alu_cdb, valid_lsb_cdb, rob_id_alu_cdb, rob_id_lsb_cdb,
           result_alu_cdb, result_lsb_cdb,
    output full, openum_to_ex, V1_to_ex, V2_to_ex, imm_to_ex, pc_to_ex, rob_id_to_ex
  );
endinterface

// File: rtl/rs_station.sv
// Reservation station for the ALU: holds dispatched ops until both operands
// are resolved via CDB snooping, then issues one ready entry per cycle.
module rs_station #(
  parameter int RS_SIZE    = 16,
  parameter int OPENUM_LEN = 6,
  parameter int DATA_LEN   = 32,
  parameter int ADDR_LEN   = 32,
  parameter int ROB_ID_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic rollback,
  rs_station_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam logic [OPENUM_LEN-1:0] OPENUM_NOP = '0;

  // Control state
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] q1_busy;
  logic [RS_SIZE-1:0] q2_busy;
  logic [RS_SIZE-1:0] ready;

  // Payload state, never reset; busy qualifies it
  logic [OPENUM_LEN-1:0] openum [RS_SIZE];
  logic [DATA_LEN-1:0]   v1     [RS_SIZE];
  logic [DATA_LEN-1:0]   v2     [RS_SIZE];
  logic [ROB_ID_LEN-1:0] q1     [RS_SIZE];
  logic [ROB_ID_LEN-1:0] q2     [RS_SIZE];
  logic [DATA_LEN-1:0]   imm    [RS_SIZE];
  logic [ADDR_LEN-1:0]   pc     [RS_SIZE];
  logic [ROB_ID_LEN-1:0] rob_id [RS_SIZE];

  logic [DATA_LEN:0] w1 [RS_SIZE];
  logic [DATA_LEN:0] w2 [RS_SIZE];
  logic [DATA_LEN:0] d1;
  logic [DATA_LEN:0] d2;

  logic [IDX_W-1:0] free_idx;
  logic             has_free;
  logic [IDX_W-1:0] iss_idx_p0;
  logic             iss_vld_p0;
  logic             run;
  logic             dsp_wr;

  // Returns {still_pending, value}; ALU CDB has priority over LSB CDB.
  function automatic logic [DATA_LEN:0] resolve(
    input logic                  q_busy,
    input logic [ROB_ID_LEN-1:0] q,
    input logic [DATA_LEN-1:0]   v,
    input logic                  va,
    input logic [ROB_ID_LEN-1:0] ta,
    input logic [DATA_LEN-1:0]   ra,
    input logic                  vl,
    input logic [ROB_ID_LEN-1:0] tl,
    input logic [DATA_LEN-1:0]   rl
  );
    if (q_busy && va && (q == ta)) return {1'b0, ra};
    if (q_busy && vl && (q == tl)) return {1'b0, rl};
    return {q_busy, v};
  endfunction

  assign ready    = busy & ~q1_busy & ~q2_busy;
  assign bus.full = &busy;
  assign run      = rdy & ~rollback & ~rst;
  assign dsp_wr   = bus.ena_dsp & has_free;

  always_comb begin
    free_idx   = '0;
    has_free   = 1'b0;
    iss_idx_p0 = '0;
    iss_vld_p0 = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx = IDX_W'(i);
        has_free = 1'b1;
      end
      if (ready[i]) begin
        iss_idx_p0 = IDX_W'(i);
        iss_vld_p0 = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w1[i] = resolve(q1_busy[i], q1[i], v1[i],
                      bus.valid_alu_cdb, bus.rob_id_alu_cdb, bus.result_alu_cdb,
                      bus.valid_lsb_cdb, bus.rob_id_lsb_cdb, bus.result_lsb_cdb);
      w2[i] = resolve(q2_busy[i], q2[i], v2[i],
                      bus.valid_alu_cdb, bus.rob_id_alu_cdb, bus.result_alu_cdb,
                      bus.valid_lsb_cdb, bus.rob_id_lsb_cdb, bus.result_lsb_cdb);
    end
    d1 = resolve(bus.Q1_busy_dsp, bus.Q1_dsp, bus.V1_dsp,
                 bus.valid_alu_cdb, bus.rob_id_alu_cdb, bus.result_alu_cdb,
                 bus.valid_lsb_cdb, bus.rob_id_lsb_cdb, bus.result_lsb_cdb);
    d2 = resolve(bus.Q2_busy_dsp, bus.Q2_dsp, bus.V2_dsp,
                 bus.valid_alu_cdb, bus.rob_id_alu_cdb, bus.result_alu_cdb,
                 bus.valid_lsb_cdb, bus.rob_id_lsb_cdb, bus.result_lsb_cdb);
  end

  // p0 -> p1: issue selection registered onto the execution-unit outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy             <= '0;
      bus.openum_to_ex <= OPENUM_NOP;
      bus.V1_to_ex     <= '0;
      bus.V2_to_ex     <= '0;
      bus.imm_to_ex    <= '0;
      bus.pc_to_ex     <= '0;
      bus.rob_id_to_ex <= '0;
    end else if (rollback) begin
      busy             <= '0;
      bus.openum_to_ex <= OPENUM_NOP;
    end else if (!rdy) begin
      bus.openum_to_ex <= OPENUM_NOP;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          q1_busy[i] <= w1[i][DATA_LEN];
          q2_busy[i] <= w2[i][DATA_LEN];
        end
      end
      if (iss_vld_p0) begin
        busy[iss_idx_p0] <= 1'b0;
        bus.openum_to_ex <= openum[iss_idx_p0];
        bus.V1_to_ex     <= v1[iss_idx_p0];
        bus.V2_to_ex     <= v2[iss_idx_p0];
        bus.imm_to_ex    <= imm[iss_idx_p0];
        bus.pc_to_ex     <= pc[iss_idx_p0];
        bus.rob_id_to_ex <= rob_id[iss_idx_p0];
      end else begin
        bus.openum_to_ex <= OPENUM_NOP;
      end
      // The free slot was not busy at cycle start, so it never collides with issue.
      if (dsp_wr) begin
        busy[free_idx]    <= 1'b1;
        q1_busy[free_idx] <= d1[DATA_LEN];
        q2_busy[free_idx] <= d2[DATA_LEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (run) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          v1[i] <= w1[i][DATA_LEN-1:0];
          v2[i] <= w2[i][DATA_LEN-1:0];
        end
      end
      if (dsp_wr) begin
        openum[free_idx] <= bus.openum_dsp;
        v1[free_idx]     <= d1[DATA_LEN-1:0];
        v2[free_idx]     <= d2[DATA_LEN-1:0];
        q1[free_idx]     <= bus.Q1_dsp;
        q2[free_idx]     <= bus.Q2_dsp;
        imm[free_idx]    <= bus.imm_dsp;
        pc[free_idx]     <= bus.pc_dsp;
        rob_id[free_idx] <= bus.rob_id_dsp;
      end
    end
  end
endmodule

// File: tb/tb_rs_station.sv
// Directed self-checking bench for rs_station: dispatch, bypass, wakeup,
// fill/full, issue order, rollback and rdy stall.
module tb_rs_station;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic rollback;
  int   total = 0;
  int   bad   = 0;

  rs_station_if #(.OPENUM_LEN(6), .DATA_LEN(32), .ADDR_LEN(32), .ROB_ID_LEN(4)) bus ();

  rs_station #(
    .RS_SIZE(16), .OPENUM_LEN(6), .DATA_LEN(32), .ADDR_LEN(32), .ROB_ID_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .rollback(rollback),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ena_dsp        = 1'b0;
    bus.openum_dsp     = '0;
    bus.V1_dsp         = '0;
    bus.V2_dsp         = '0;
    bus.Q1_busy_dsp    = 1'b0;
    bus.Q2_busy_dsp    = 1'b0;
    bus.Q1_dsp         = '0;
    bus.Q2_dsp         = '0;
    bus.imm_dsp        = '0;
    bus.pc_dsp         = '0;
    bus.rob_id_dsp     = '0;
    bus.valid_alu_cdb  = 1'b0;
    bus.valid_lsb_cdb  = 1'b0;
    bus.rob_id_alu_cdb = '0;
    bus.rob_id_lsb_cdb = '0;
    bus.result_alu_cdb = '0;
    bus.result_lsb_cdb = '0;
  endtask

  task automatic dsp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic qb1, input logic [3:0] t1,
                     input logic qb2, input logic [3:0] t2,
                     input logic [3:0] rob, input logic [31:0] pcv, input logic [31:0] immv);
    bus.ena_dsp     = 1'b1;
    bus.openum_dsp  = op;
    bus.V1_dsp      = a;
    bus.V2_dsp      = b;
    bus.Q1_busy_dsp = qb1;
    bus.Q1_dsp      = t1;
    bus.Q2_busy_dsp = qb2;
    bus.Q2_dsp      = t2;
    bus.rob_id_dsp  = rob;
    bus.pc_dsp      = pcv;
    bus.imm_dsp     = immv;
  endtask

  task automatic cdb_alu(input logic [3:0] t, input logic [31:0] v);
    bus.valid_alu_cdb  = 1'b1;
    bus.rob_id_alu_cdb = t;
    bus.result_alu_cdb = v;
  endtask

  task automatic cdb_lsb(input logic [3:0] t, input logic [31:0] v);
    bus.valid_lsb_cdb  = 1'b1;
    bus.rob_id_lsb_cdb = t;
    bus.result_lsb_cdb = v;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    tick(); tick();
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_op", 32'(bus.openum_to_ex), 0);
    chk("rst_v1", bus.V1_to_ex, 0);
    chk("rst_v2", bus.V2_to_ex, 0);
    chk("rst_imm", bus.imm_to_ex, 0);
    chk("rst_pc", bus.pc_to_ex, 0);
    chk("rst_rob", 32'(bus.rob_id_to_ex), 0);
    rst = 1'b0;

    // Ready ADD: issues one edge after dispatch
    dsp(6'd1, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 32'h100, 32'd3);
    tick(); idle_inputs();
    chk("add_not_yet", 32'(bus.openum_to_ex), 0);
    tick();
    chk("add_op", 32'(bus.openum_to_ex), 1);
    chk("add_v1", bus.V1_to_ex, 5);
    chk("add_v2", bus.V2_to_ex, 7);
    chk("add_pc", bus.pc_to_ex, 32'h100);
    chk("add_imm", bus.imm_to_ex, 3);
    chk("add_rob", 32'(bus.rob_id_to_ex), 1);
    tick();
    chk("add_nop", 32'(bus.openum_to_ex), 0);
    chk("add_v1_hold", bus.V1_to_ex, 5);

    // SUB blocked on tag 3, woken by LSB CDB
    dsp(6'd2, 32'd0, 32'd9, 1'b1, 4'd3, 1'b0, 4'd0, 4'd2, 32'h104, 32'd0);
    tick(); idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sub_wait", 32'(bus.openum_to_ex), 0);
    end
    cdb_lsb(4'd3, 32'h10);
    tick(); idle_inputs();
    chk("sub_wake_edge", 32'(bus.openum_to_ex), 0);
    tick();
    chk("sub_op", 32'(bus.openum_to_ex), 2);
    chk("sub_v1", bus.V1_to_ex, 32'h10);
    chk("sub_v2", bus.V2_to_ex, 9);
    tick();

    // Dispatch-time bypass from ALU CDB on operand 2
    dsp(6'd1, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd3, 32'h108, 32'd0);
    cdb_alu(4'd6, 32'hAB);
    tick(); idle_inputs();
    tick();
    chk("byp_op", 32'(bus.openum_to_ex), 1);
    chk("byp_v2", bus.V2_to_ex, 32'hAB);
    tick();

    // Both CDBs carry the same tag at dispatch: ALU wins
    dsp(6'd3, 32'd0, 32'd2, 1'b1, 4'd5, 1'b0, 4'd0, 4'd4, 32'h10C, 32'd0);
    cdb_alu(4'd5, 32'h11);
    cdb_lsb(4'd5, 32'h22);
    tick(); idle_inputs();
    tick();
    chk("both_dsp_op", 32'(bus.openum_to_ex), 3);
    chk("both_dsp_v1", bus.V1_to_ex, 32'h11);
    tick();

    // Both CDBs carry the same tag at wakeup: ALU wins
    dsp(6'd4, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd7, 4'd5, 32'h110, 32'd0);
    tick(); idle_inputs();
    cdb_alu(4'd7, 32'h33);
    cdb_lsb(4'd7, 32'h44);
    tick(); idle_inputs();
    tick();
    chk("both_wk_op", 32'(bus.openum_to_ex), 4);
    chk("both_wk_v2", bus.V2_to_ex, 32'h33);
    tick();

    // Fill all 16 entries; entry i waits on tag i, rob_id i, V2 i
    for (int i = 0; i < 16; i++) begin
      dsp(6'd5, 32'd0, 32'(i), 1'b1, 4'(i), 1'b0, 4'd0, 4'(i), 32'h200 + 32'(4 * i), 32'd0);
      tick();
      if (i == 14) chk("fill15_full", 32'(bus.full), 0);
    end
    idle_inputs();
    chk("fill16_full", 32'(bus.full), 1);
    chk("fill_no_issue", 32'(bus.openum_to_ex), 0);
    cdb_alu(4'd9, 32'h99);
    tick(); idle_inputs();
    chk("wk9_still_full", 32'(bus.full), 1);
    tick();
    chk("iss9_op", 32'(bus.openum_to_ex), 5);
    chk("iss9_rob", 32'(bus.rob_id_to_ex), 9);
    chk("iss9_v1", bus.V1_to_ex, 32'h99);
    chk("iss9_full", 32'(bus.full), 0);

    // Wake 12 and 4 together: lowest index issues first
    cdb_lsb(4'd12, 32'hC0);
    cdb_alu(4'd4, 32'h40);
    tick(); idle_inputs();
    tick();
    chk("ord_first", 32'(bus.rob_id_to_ex), 4);
    chk("ord_first_v1", bus.V1_to_ex, 32'h40);
    tick();
    chk("ord_second", 32'(bus.rob_id_to_ex), 12);
    chk("ord_second_v1", bus.V1_to_ex, 32'hC0);
    chk("ord_second_pc", bus.pc_to_ex, 32'h230);

    // Refill slots 4 and 9, leaving slot 12 as the only free one
    dsp(6'd7, 32'd0, 32'd0, 1'b1, 4'd14, 1'b0, 4'd0, 4'd14, 32'h300, 32'd0);
    tick();
    dsp(6'd7, 32'd0, 32'd0, 1'b1, 4'd14, 1'b0, 4'd0, 4'd14, 32'h304, 32'd0);
    tick(); idle_inputs();
    chk("one_free_full", 32'(bus.full), 0);
    cdb_lsb(4'd0, 32'h0F);
    tick(); idle_inputs();
    // Issue of entry 0 and dispatch into slot 12 on the same edge
    dsp(6'd6, 32'h66, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13, 32'h308, 32'd0);
    tick(); idle_inputs();
    chk("same_cyc_full", 32'(bus.full), 0);
    chk("same_cyc_rob", 32'(bus.rob_id_to_ex), 0);
    chk("same_cyc_v1", bus.V1_to_ex, 32'h0F);
    tick();
    chk("new_iss_op", 32'(bus.openum_to_ex), 6);
    chk("new_iss_rob", 32'(bus.rob_id_to_ex), 13);
    chk("new_iss_v1", bus.V1_to_ex, 32'h66);

    // Rollback with a ready entry present plus dispatch and CDB in that cycle
    cdb_alu(4'd2, 32'h22);
    tick(); idle_inputs();
    rollback = 1'b1;
    dsp(6'd9, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8, 32'h400, 32'd0);
    cdb_alu(4'd1, 32'h01);
    tick(); idle_inputs();
    rollback = 1'b0;
    chk("rb_full", 32'(bus.full), 0);
    chk("rb_op", 32'(bus.openum_to_ex), 0);
    tick();
    chk("rb_no_dsp", 32'(bus.openum_to_ex), 0);
    cdb_alu(4'd1, 32'h01);
    cdb_lsb(4'd14, 32'hEE);
    tick(); idle_inputs();
    tick();
    chk("rb_no_wake", 32'(bus.openum_to_ex), 0);
    chk("rb_full2", 32'(bus.full), 0);

    // rdy low for 3 cycles with a ready entry held
    dsp(6'd8, 32'h55, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5, 32'h500, 32'd0);
    tick(); idle_inputs();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dsp(6'd10, 32'h77, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6, 32'h504, 32'd0);
      tick();
      chk("stall_nop", 32'(bus.openum_to_ex), 0);
    end
    idle_inputs();
    chk("stall_full", 32'(bus.full), 0);
    rdy = 1'b1;
    tick();
    chk("resume_op", 32'(bus.openum_to_ex), 8);
    chk("resume_v1", bus.V1_to_ex, 32'h55);
    chk("resume_rob", 32'(bus.rob_id_to_ex), 5);
    tick();
    chk("resume_after", 32'(bus.openum_to_ex), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
